// File: rtl/hilo_mult_if.sv
// Issue/read bundle between the decode stage and the HI/LO multiply unit.
// The master side is the pipeline (decoder/consumer); the slave side is the unit.
interface hilo_mult_if;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  regsel;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, alu_op, op_a, op_b, regsel,
        input  rd_data, busy, done, stall, hi, lo
    );

    modport slave (
        input  start, alu_op, op_a, op_b, regsel,
        output rd_data, busy, done, stall, hi, lo
    );
endinterface

// File: rtl/hilo_mult_unit.sv
// Iterative 32x32 mult/multu unit with HI/LO result registers.
// Radix-2 shift-add over unsigned magnitudes; the sign is re-applied on the
// final step so HI/LO change on exactly one edge per multiply.
module hilo_mult_unit (
    input  logic       clk,
    input  logic       rst,
    hilo_mult_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] OP_MULT = 4'b0110;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg;
    logic [63:0] acc_reg;
    logic [63:0] mcand_reg;
    logic [32:0] mplier_reg;
    logic        neg_reg;
    logic [31:0] hi_reg, lo_reg;

    logic        accept;
    logic        signed_mode;
    logic [32:0] mag_a, mag_b;
    logic [63:0] add_term;
    logic [63:0] acc_sum;
    logic [63:0] product;
    logic        last_step;

    // A start is only honoured from IDLE; starts while busy are dropped.
    assign accept      = (state_reg == IDLE) && bus.start;
    assign signed_mode = (bus.alu_op == OP_MULT);
    assign last_step   = (state_reg == RUN) && (cnt_reg == 6'd31);

    // 33-bit magnitudes so that -2^31 maps to +2^31 without overflow.
    assign mag_a = (signed_mode && bus.op_a[31]) ? (33'd0 - {1'b1, bus.op_a}) : {1'b0, bus.op_a};
    assign mag_b = (signed_mode && bus.op_b[31]) ? (33'd0 - {1'b1, bus.op_b}) : {1'b0, bus.op_b};

    assign add_term = mplier_reg[0] ? mcand_reg : 64'd0;
    assign acc_sum  = acc_reg + add_term;
    // Negating a zero sum yields zero, so a zero operand never produces -0 garbage.
    assign product  = neg_reg ? (64'd0 - acc_sum) : acc_sum;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on accepted start, RUN for 32 steps, one DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt_reg == 6'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add steps and the single HI/LO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else if (accept) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= {31'd0, mag_a};
            mplier_reg <= mag_b;
            neg_reg    <= signed_mode && (bus.op_a[31] ^ bus.op_b[31]);
        end else if (state_reg == RUN) begin
            acc_reg    <= acc_sum;
            mcand_reg  <= {mcand_reg[62:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[32:1]};
            cnt_reg    <= cnt_reg + 6'd1;
            if (last_step) begin
                hi_reg <= product[63:32];
                lo_reg <= product[31:0];
            end
        end
    end

    assign bus.busy  = (state_reg != IDLE);
    assign bus.done  = (state_reg == DONE);
    assign bus.stall = bus.busy && ((bus.regsel == 2'b01) || (bus.regsel == 2'b10) || bus.start);
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

    // Read mux built per bit: HI on 01, LO on 10, zero otherwise.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rd
            assign bus.rd_data[gi] = ((bus.regsel == 2'b01) && hi_reg[gi]) ||
                                     ((bus.regsel == 2'b10) && lo_reg[gi]);
        end
    endgenerate
endmodule

// File: doc/hilo_mult_unit.md
HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, ports named clk and rst; no other clock or reset SHALL exist.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 Port start  input  1  mult/multu issue strobe, driven from the decoder's enhilo_EX.
REQ-005 Port alu_op  input  4  operation code; 4'b0110 = mult (signed), 4'b0111 = multu (unsigned); all other values are treated as multu when start is high.
REQ-006 Port op_a  input  32  rs operand, sampled only on an accepted start.
REQ-007 Port op_b  input  32  rt operand, sampled only on an accepted start.
REQ-008 Port regsel  input  2  read select from the decoder; 2'b01 = mfhi, 2'b10 = mflo, 2'b00/2'b11 = no read.
REQ-009 Port rd_data  output  32  HI when regsel=01, LO when regsel=10, 32'h0 otherwise; combinational from the HI/LO registers.
REQ-010 Port busy  output  1  high while state is not IDLE.
REQ-011 Port done  output  1  single-cycle pulse in state DONE.
REQ-012 Port stall  output  1  pipeline hold request to fetch/decode.
REQ-013 Port hi  output  32  HI register; port lo  output  32  LO register.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 IDLE->RUN when start=1 in IDLE: latch the operands, sign mode, |op_a| and |op_b| (magnitudes are taken only in signed mode), negate flag = op_a[31]^op_b[31] (signed only), and clear the 6-bit iteration counter and the 64-bit accumulator.
REQ-016 RUN: one radix-2 shift-add step per cycle, 32 steps; counter increments 0..31.
REQ-017 RUN->DONE on the edge that completes step 31: the final 64-bit product, two's-complement negated if the negate flag is set, SHALL be written to {hi,lo} on that same edge.
REQ-018 DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-019 Latency: start sampled at edge N gives a new hi/lo visible after edge N+32, done high during cycle N+32..N+33, and IDLE from edge N+33; total occupancy is 33 cycles.
REQ-020 HI/LO SHALL hold their values at all times except the REQ-017 write and reset.
REQ-021 start while busy=1 SHALL be ignored (no operand capture, no restart) and SHALL force stall=1 that cycle.
REQ-022 stall = busy & ((regsel==01)|(regsel==10)|start); a start in IDLE SHALL NOT raise stall.
REQ-023 When busy=1, rd_data SHALL return the old HI/LO; the consumer is held by stall until the update is visible.
REQ-024 start and regsel!=0 in the same IDLE cycle: rd_data SHALL return the pre-multiply HI/LO, and the multiply SHALL start.
REQ-025 Signed edge cases: the magnitude of 32'h80000000 is 2^31 (33-bit internal magnitude); a zero operand SHALL yield 64'h0 regardless of the negate flag.

Reset
REQ-026 rst=1 at any edge, including mid-RUN, SHALL force state IDLE, hi=0, lo=0, counter=0, and accumulator=0, with busy=0, done=0, and stall=0 in the following cycle.
REQ-027 rst SHALL take priority over start on the same edge; that start is discarded.

Verification
REQ-028 multu 32'hFFFFFFFF x 32'hFFFFFFFF -> after 33 cycles hi=32'hFFFFFFFE, lo=32'h00000001, done pulses once.
REQ-029 mult 32'hFFFFFFFF x 32'h00000002 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFE; mult 32'h80000000 x 32'h80000000 -> hi=32'h40000000, lo=0.
REQ-030 mult 7 x 0 with prior hi/lo = 32'h1234/32'h5678 -> hi=0, lo=0; before the write, regsel=01 during busy -> stall=1, rd_data=32'h1234.
REQ-031 Second start at cycle 5 of a run -> ignored, stall=1 that cycle, result equals the first operands' product, and completion stays at cycle 33.
REQ-032 rst asserted at RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a new start then completes normally in 33 cycles.
